// File: rtl/t05_cb_gen_pkg.sv
// Shared types and node-word layout helpers for the Huffman codebook synthesiser.
// Field offsets are functions so that non-default widths stay consistent everywhere.
package t05_cb_gen_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_LEFT,
        ST_RIGHT,
        ST_EMIT,
        ST_BACKTRACK,
        ST_DONE,
        ST_ERROR
    } cb_state_t;

    localparam int DEF_SYM_W = 8;
    localparam int DEF_IDX_W = 7;
    localparam int DEF_SUM_W = 46;

    // Node word is {hdr(IDX_W), left(1+SYM_W), right(1+SYM_W), sum(SUM_W)}, MSB first.
    function automatic int node_width(input int idx_w, input int sym_w, input int sum_w);
        return idx_w + 2 * (1 + sym_w) + sum_w;
    endfunction

    function automatic int right_lsb(input int sum_w);
        return sum_w;
    endfunction

    function automatic int left_lsb(input int sym_w, input int sum_w);
        return sum_w + 1 + sym_w;
    endfunction

    localparam int NODE_W = node_width(DEF_IDX_W, DEF_SYM_W, DEF_SUM_W);

    // A right child of all ones marks a tree that holds a single symbol.
    localparam logic [DEF_SYM_W:0] SINGLE_SENTINEL = '1;

    function automatic logic child_is_leaf(input logic is_node_bit);
        return !is_node_bit;
    endfunction

endpackage

// File: rtl/t05_cb_path_stack.sv
// LIFO of {node index, side} entries recording the current root-to-node path.
// Side bit 0 means the left subtree is in progress, 1 means the right one.
module t05_cb_path_stack #(
    parameter int IDX_W = 7,
    parameter int DEPTH = 128
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             clear,
    input  logic             push,
    input  logic [IDX_W-1:0] push_idx,
    input  logic             pop,
    input  logic             set_side,
    output logic [IDX_W-1:0] top_idx,
    output logic             top_side,
    output logic             empty,
    output logic             full
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [IDX_W:0]     mem_q [DEPTH];
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   top_ptr;
    logic [PTR_W-1:0]   wr_ptr;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CNT_W'(DEPTH));
    assign top_ptr  = PTR_W'(cnt_q - CNT_W'(1));
    assign wr_ptr   = PTR_W'(cnt_q);
    assign top_idx  = mem_q[top_ptr][IDX_W:1];
    assign top_side = mem_q[top_ptr][0];

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (push && !full) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop && !empty) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Entry storage carries no reset; only entries below cnt_q are ever read.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[wr_ptr] <= {push_idx, 1'b0};
        end else if (set_side && !empty) begin
            mem_q[top_ptr][0] <= 1'b1;
        end
    end

endmodule

// File: rtl/t05_cb_synthesis_gen.sv
// Codebook synthesiser: depth-first walk of a Huffman tree in external SRAM,
// emitting one {symbol, path, length} record per leaf over a valid/ready stream.
module t05_cb_synthesis_gen
    import t05_cb_gen_pkg::*;
#(
    parameter int SYM_W      = 8,
    parameter int IDX_W      = 7,
    parameter int SUM_W      = 46,
    parameter int MAX_DEPTH  = 128,
    localparam int NODE_BITS = node_width(IDX_W, SYM_W, SUM_W),
    localparam int LEN_W     = $clog2(MAX_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 start,
    input  logic [IDX_W-1:0]     max_index,
    output logic                 rd_req,
    output logic [IDX_W-1:0]     rd_addr,
    input  logic                 rd_valid,
    input  logic [NODE_BITS-1:0] rd_data,
    output logic                 code_valid,
    input  logic                 code_ready,
    output logic [SYM_W-1:0]     code_sym,
    output logic [MAX_DEPTH-1:0] code_path,
    output logic [LEN_W-1:0]     code_len,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    localparam int CH_W      = 1 + SYM_W;
    localparam int RIGHT_LSB = right_lsb(SUM_W);
    localparam int LEFT_LSB  = left_lsb(SYM_W, SUM_W);

    cb_state_t            state_q, state_d;
    logic [IDX_W-1:0]     target_q, target_d;
    logic                 refetch_q, refetch_d;
    logic [CH_W-1:0]      left_q, left_d;
    logic [CH_W-1:0]      right_q, right_d;
    logic [MAX_DEPTH-1:0] path_q, path_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [SYM_W-1:0]     sym_q, sym_d;
    logic                 err_q, err_d;
    logic                 done_q, done_d;
    logic                 single_q, single_d;

    logic                 stk_clear, stk_push, stk_pop, stk_set_side;
    logic [IDX_W-1:0]     stk_top_idx;
    logic                 stk_top_side, stk_empty, stk_full;

    t05_cb_path_stack #(
        .IDX_W (IDX_W),
        .DEPTH (MAX_DEPTH)
    ) u_stack (
        .clk      (clk),
        .nrst     (nrst),
        .clear    (stk_clear),
        .push     (stk_push),
        .push_idx (target_q),
        .pop      (stk_pop),
        .set_side (stk_set_side),
        .top_idx  (stk_top_idx),
        .top_side (stk_top_side),
        .empty    (stk_empty),
        .full     (stk_full)
    );

    // Header, frequency sum and child bits beyond IDX_W are deliberately ignored.
    logic unused_bits;
    assign unused_bits = ^{rd_data, left_q, right_q};

    assign rd_addr   = target_q;
    assign code_sym  = sym_q;
    assign code_path = path_q;
    assign code_len  = len_q;
    assign err       = err_q;
    assign done      = done_q;
    assign busy      = !(state_q inside {ST_IDLE, ST_DONE, ST_ERROR});

    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        refetch_d    = refetch_q;
        left_d       = left_q;
        right_d      = right_q;
        path_d       = path_q;
        len_d        = len_q;
        sym_d        = sym_q;
        err_d        = err_q;
        single_d     = single_q;
        done_d       = 1'b0;
        stk_clear    = 1'b0;
        stk_push     = 1'b0;
        stk_pop      = 1'b0;
        stk_set_side = 1'b0;
        rd_req       = 1'b0;
        code_valid   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d   = ST_FETCH;
                    target_d  = max_index;
                    refetch_d = 1'b0;
                    path_d    = '0;
                    len_d     = '0;
                    err_d     = 1'b0;
                    single_d  = 1'b0;
                    stk_clear = 1'b1;
                end
            end
            ST_FETCH, ST_WAIT: begin
                rd_req = 1'b1;
                if (rd_valid) begin
                    left_d  = rd_data[LEFT_LSB +: CH_W];
                    right_d = rd_data[RIGHT_LSB +: CH_W];
                    if (refetch_q) begin
                        state_d = ST_RIGHT;
                    end else begin
                        state_d = ST_LEFT;
                        // Only the root (fetched with an empty stack) can flag a single-symbol tree.
                        if (stk_empty && (&rd_data[RIGHT_LSB +: CH_W])) begin
                            single_d = 1'b1;
                        end
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_LEFT: begin
                if (stk_full) begin
                    state_d = ST_ERROR;
                    err_d   = 1'b1;
                end else begin
                    stk_push = 1'b1;
                    path_d   = path_q << 1;
                    len_d    = len_q + LEN_W'(1);
                    if (child_is_leaf(left_q[CH_W-1])) begin
                        sym_d   = left_q[SYM_W-1:0];
                        state_d = ST_EMIT;
                    end else begin
                        target_d  = left_q[IDX_W-1:0];
                        refetch_d = 1'b0;
                        state_d   = ST_FETCH;
                    end
                end
            end
            ST_RIGHT: begin
                stk_set_side = 1'b1;
                path_d       = {path_q[MAX_DEPTH-1:1], 1'b1};
                if (child_is_leaf(right_q[CH_W-1])) begin
                    sym_d   = right_q[SYM_W-1:0];
                    state_d = ST_EMIT;
                end else begin
                    target_d  = right_q[IDX_W-1:0];
                    refetch_d = 1'b0;
                    state_d   = ST_FETCH;
                end
            end
            ST_EMIT: begin
                code_valid = 1'b1;
                if (code_ready) begin
                    state_d = ST_BACKTRACK;
                end
            end
            ST_BACKTRACK: begin
                if (single_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (!stk_top_side) begin
                    target_d  = stk_top_idx;
                    refetch_d = 1'b1;
                    state_d   = ST_FETCH;
                end else begin
                    stk_pop = 1'b1;
                    path_d  = path_q >> 1;
                    len_d   = len_q - LEN_W'(1);
                    if (len_q == LEN_W'(1)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= ST_IDLE;
            target_q  <= '0;
            refetch_q <= 1'b0;
            left_q    <= '0;
            right_q   <= '0;
            path_q    <= '0;
            len_q     <= '0;
            sym_q     <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            single_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            refetch_q <= refetch_d;
            left_q    <= left_d;
            right_q   <= right_d;
            path_q    <= path_d;
            len_q     <= len_d;
            sym_q     <= sym_d;
            err_q     <= err_d;
            done_q    <= done_d;
            single_q  <= single_d;
        end
    end

endmodule
